// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the mux select arbiter and its requesters/consumer.
// master drives the mux select side, slave drives requests and ack.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic       ack;
  logic       s0;
  logic       s1;
  logic       valid;
  logic [3:0] grant;
  logic       timeout;

  modport master (
    input  req,
    input  ack,
    output s0,
    output s1,
    output valid,
    output grant,
    output timeout
  );

  modport slave (
    output req,
    output ack,
    input  s0,
    input  s1,
    input  valid,
    input  grant,
    input  timeout
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the s1:s0 select of the upstream 4:1 mux.
// Holds a grant until ack or until TIMEOUT cycles elapse without ack.
module mux_sel_arbiter #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input logic               clk,
  input logic               rst,
  mux_sel_arbiter_if.master bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic             valid;
  logic [3:0]       grant;
  logic             timeout;
  logic [1:0]       pick;
  logic [1:0]       idx;

  // Scan ptr+4 down to ptr+1 so the lowest offset found wins.
  always_comb begin
    pick = ptr + 2'd1;
    idx  = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (bus.req[idx]) pick = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 2'd3;
      sel     <= 2'd0;
      valid   <= 1'b0;
      grant   <= 4'b0000;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|bus.req) begin
            sel   <= pick;
            grant <= 4'b0001 << pick;
            valid <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.ack || cnt == CNT_W'(TIMEOUT - 1)) begin
            valid   <= 1'b0;
            grant   <= 4'b0000;
            ptr     <= sel;
            timeout <= ~bus.ack;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s0      = sel[0];
  assign bus.s1      = sel[1];
  assign bus.valid   = valid;
  assign bus.grant   = grant;
  assign bus.timeout = timeout;

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that drives the select pins (s0, s1) of the 4:1 mux (mux41) directly upstream of it.
- Four sources raise requests. The block grants one at a time and presents the granted index on s1:s0, with a valid flag.
- It holds the select stable until the downstream consumer acks, or until a timeout expires.
- It owns the mux select timing, so the mux stays purely combinational.

Parameters:
- TIMEOUT, 8, number of cycles a grant is held without ack before forced release; legal range is 1 or more.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request per mux input; req[i] requests mux input a[i].
- ack  input  1  consumer has taken the selected data; sampled only in BUSY.
- s0  output  1  mux select LSB, registered.
- s1  output  1  mux select MSB, registered; selected index = 2*s1 + s0.
- valid  output  1  s1:s0 holds a live grant.
- grant  output  4  one-hot copy of the granted index; all zeros when not valid.
- timeout  output  1  one-cycle pulse when a grant is released by timeout.

Behaviour:
- All outputs are registered. rst high asynchronously forces:
  - s0=0, s1=0, valid=0, grant=4'b0000, timeout=0;
  - hold counter cnt=0, last-grant pointer ptr=3, state=IDLE.
- Reset mid-grant takes effect immediately. The in-flight grant is dropped with no timeout pulse. After reset, the priority search restarts at index 0.
- States are IDLE and BUSY.
- IDLE:
  - valid=0, grant=0. ack is ignored.
  - At a rising edge with req != 0, the block selects the first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - It loads {s1,s0}=index, grant=1<<index, valid=1, cnt=0, and moves to BUSY.
  - Latency: req seen at edge k gives valid high immediately after edge k.
- BUSY:
  - s1:s0 and grant are frozen. Changes on req, including dropping the granted req, are ignored until release.
  - Each edge with ack=1 releases the grant: valid=0, grant=0, ptr=granted index, state goes to IDLE.
  - Each edge with ack=0 and cnt==TIMEOUT-1 also releases the same way and pulses timeout=1 for exactly one cycle.
  - Otherwise cnt increments.
  - A timeout release therefore gives valid high for exactly TIMEOUT cycles.
  - If ack and the timeout condition occur on the same edge, ack wins and timeout stays 0.
- s0 and s1 keep their last value after release; the consumer must qualify them with valid.
- Every release is followed by at least one IDLE cycle, so there are no back-to-back grants and valid drops for at least one cycle.
- Fairness: with all four req held high and ack each grant, the grant order from reset is 0,1,2,3,0,...
- req=0 in IDLE keeps the block in IDLE, with all outputs at their reset values except s0/s1, which hold.
- cnt never exceeds TIMEOUT-1.

Test Plan:
- Reset check: assert rst mid-cycle -> outputs clear without a clock edge; s1:s0=00, valid=0, grant=0000, timeout=0.
- Rotation: req=4'b1111 held, ack pulsed one cycle after each valid rise -> grant sequence 0001, 0010, 0100, 1000, 0001. Matching s1:s0 is 00, 01, 10, 11, 00, with one valid-low cycle between grants.
- Sparse and skip:
  - req=4'b1010 from reset, with ack -> grant 0010 (s1:s0=01), then 1000 (11), then 0010 again.
  - Connected mux41 with a=4'b1000 -> o=1 only while s1:s0=11.
- Timeout: req=4'b0100, ack held 0, TIMEOUT=8 -> valid high for exactly 8 cycles with s1:s0=10. timeout pulses 1 cycle on the release edge, then the block regrants index 2 after one IDLE cycle.
- Collision and freeze:
  - ack=1 on the edge where cnt==7 -> release with timeout=0.
  - During BUSY on index 1, req changes from 0010 to 0001 -> s1:s0 stays 01 until ack.
- Reset mid-grant: with index 3 granted and cnt=5, pulse rst -> valid=0 immediately, no timeout pulse. Next grant with req=1111 is index 0.
